// File: rtl/ram_dual_pkg.sv
// Shared definitions for the self-initialising dual-port RAM: controller state
// encoding and default geometry.
package ram_dual_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 6;

  typedef enum logic {
    INIT,
    READY
  } state_e;

endpackage

// File: rtl/ram_dual_init_ctrl.sv
// Initialisation controller: after reset, sweeps init_cnt over 0..DEPTH-1
// (one address per cycle), then parks in READY. busy is high for the sweep.
module ram_dual_init_ctrl
  import ram_dual_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] init_cnt_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next state: advance the sweep, leave INIT right after the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // State register; reset always restarts the sweep from address 0.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs derived straight from state.
  always_comb begin
    busy_o     = (state_q == INIT);
    init_cnt_o = cnt_q;
  end

endmodule

// File: rtl/ram_dual_init.sv
// Simple dual-port RAM (one write port, one registered read port) that clears
// itself to zero after every reset. Reads see same-edge writes (write-first).
// Optional per-word even parity with error injection: RAM_DUAL_INIT_PARITY_EN.
module ram_dual_init
  import ram_dual_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              re,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
`ifdef RAM_DUAL_INIT_PARITY_EN
  ,
  input  logic              inj_err,
  output logic              parity_err
`endif
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] init_cnt;
  logic              wr_in_range, rd_in_range, wr_hit, rd_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef RAM_DUAL_INIT_PARITY_EN
  logic mem_wpar, rd_par;
  logic parity_err_q, parity_err_d;
  logic mem_par [DEPTH];
`endif

  ram_dual_init_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ctrl (
    .clock_i    (clock),
    .reset_i    (reset),
    .busy_o     (busy),
    .init_cnt_o (init_cnt)
  );

  // Write port mux: the init sweep owns the array while busy.
  always_comb begin
    wr_in_range = ({1'b0, write_addr} < DepthL);
    mem_we      = 1'b0;
    mem_waddr   = write_addr;
    mem_wdata   = data;
`ifdef RAM_DUAL_INIT_PARITY_EN
    mem_wpar    = (^data) ^ inj_err;
`endif
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = '0;
`ifdef RAM_DUAL_INIT_PARITY_EN
      mem_wpar  = 1'b0;
`endif
    end else if (we && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; deliberately not reset, the sweep clears it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef RAM_DUAL_INIT_PARITY_EN
      mem_par[mem_waddr] <= mem_wpar;
`endif
    end
  end

  // Read path: range check, write-first bypass, next value of the output reg.
  always_comb begin
    rd_en       = re && !busy;
    rd_in_range = ({1'b0, read_addr} < DepthL);
    wr_hit      = we && wr_in_range && (write_addr == read_addr);
    q_d         = q_q;
    q_valid_d   = 1'b0;
`ifdef RAM_DUAL_INIT_PARITY_EN
    rd_par       = 1'b0;
    parity_err_d = 1'b0;
`endif
    if (rd_en) begin
      q_valid_d = 1'b1;
      if (!rd_in_range) begin
        q_d = '0;
      end else if (wr_hit) begin
        q_d = data;
`ifdef RAM_DUAL_INIT_PARITY_EN
        rd_par = mem_wpar;
`endif
      end else begin
        q_d = mem[read_addr];
`ifdef RAM_DUAL_INIT_PARITY_EN
        rd_par = mem_par[read_addr];
`endif
      end
`ifdef RAM_DUAL_INIT_PARITY_EN
      parity_err_d = rd_in_range && ((^q_d) != rd_par);
`endif
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
`ifdef RAM_DUAL_INIT_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
`ifdef RAM_DUAL_INIT_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
`ifdef RAM_DUAL_INIT_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ram_dual_init.sv
// Directed bench for ram_dual_init: a DEPTH=64 instance (a_*) and a DEPTH=48
// instance (b_*) sharing clock and reset.
module tb_ram_dual_init;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] a_data, a_q, b_data, b_q;
  logic [5:0] a_waddr, a_raddr, b_waddr, b_raddr;
  logic       a_we, a_re, a_qv, a_busy, b_we, b_re, b_qv, b_busy;
`ifdef RAM_DUAL_INIT_PARITY_EN
  logic       a_inj, a_perr, b_inj, b_perr;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          n_busy;
  logic        saw_valid;

  always #5 clock = ~clock;

  ram_dual_init #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .data       (a_data),
    .write_addr (a_waddr),
    .we         (a_we),
    .read_addr  (a_raddr),
    .re         (a_re),
    .q          (a_q),
    .q_valid    (a_qv),
    .busy       (a_busy)
`ifdef RAM_DUAL_INIT_PARITY_EN
    ,
    .inj_err    (a_inj),
    .parity_err (a_perr)
`endif
  );

  ram_dual_init #(.DATA_W(8), .ADDR_W(6), .DEPTH(48)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .data       (b_data),
    .write_addr (b_waddr),
    .we         (b_we),
    .read_addr  (b_raddr),
    .re         (b_re),
    .q          (b_q),
    .q_valid    (b_qv),
    .busy       (b_busy)
`ifdef RAM_DUAL_INIT_PARITY_EN
    ,
    .inj_err    (b_inj),
    .parity_err (b_perr)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count cycles with a_busy high (bounded) and note any q_valid meanwhile.
  task automatic count_busy(output int n, output logic valid_seen);
    n = 0;
    valid_seen = 1'b0;
    while (a_busy === 1'b1 && n < 200) begin
      tick();
      n++;
      if (a_qv !== 1'b0) valid_seen = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    a_data = '0; a_waddr = '0; a_raddr = '0; a_we = 1'b0; a_re = 1'b0;
    b_data = '0; b_waddr = '0; b_raddr = '0; b_we = 1'b0; b_re = 1'b0;
`ifdef RAM_DUAL_INIT_PARITY_EN
    a_inj = 1'b0; b_inj = 1'b0;
`endif
    repeat (3) tick();
    check("rst_q", a_q, 8'h00);
    check("rst_qv", a_qv, 1'b0);
    check("rst_busy", a_busy, 1'b1);
    check("rst_busy_b", b_busy, 1'b1);

    // Initial sweep; write/read attempts during busy must be ignored.
    reset = 1'b0;
    a_we = 1'b1; a_waddr = 6'd0; a_data = 8'hEE; a_re = 1'b1; a_raddr = 6'd0;
    count_busy(n_busy, saw_valid);
    a_we = 1'b0; a_re = 1'b0;
    check("init_cycles", n_busy, 64);
    check("init_no_valid", saw_valid, 1'b0);
    check("init_busy_b_done", b_busy, 1'b0);

    // Every word reads back zero, one result per cycle.
    for (int i = 0; i < 64; i++) begin
      a_re = 1'b1; a_raddr = 6'(i);
      tick();
      check("init_rd", {a_qv, a_q}, {1'b1, 8'h00});
    end
    a_re = 1'b0;
    tick();
    check("idle_qv", a_qv, 1'b0);

    // Write then read.
    a_we = 1'b1; a_waddr = 6'd5; a_data = 8'hA5;
    tick();
    a_we = 1'b0; a_re = 1'b1; a_raddr = 6'd5;
    tick();
    check("wr_rd_q", a_q, 8'hA5);
    check("wr_rd_qv", a_qv, 1'b1);
    a_re = 1'b0;
    tick();
    check("hold_qv", a_qv, 1'b0);
    check("hold_q", a_q, 8'hA5);

    // Same-address collision returns new data.
    a_we = 1'b1; a_re = 1'b1; a_waddr = 6'd9; a_raddr = 6'd9; a_data = 8'h3C;
    tick();
    check("collide_q", {a_qv, a_q}, {1'b1, 8'h3C});
    a_re = 1'b0;

    // Back-to-back writes then pipelined reads.
    a_waddr = 6'd10; a_data = 8'h11;
    tick();
    a_waddr = 6'd11; a_data = 8'h22;
    tick();
    a_we = 1'b0; a_re = 1'b1; a_raddr = 6'd10;
    tick();
    check("b2b_rd10", {a_qv, a_q}, {1'b1, 8'h11});
    a_raddr = 6'd11;
    tick();
    check("b2b_rd11", {a_qv, a_q}, {1'b1, 8'h22});
    a_raddr = 6'd9;
    tick();
    check("b2b_rd9", {a_qv, a_q}, {1'b1, 8'h3C});
    a_re = 1'b0;

    // Out-of-range on the DEPTH=48 instance.
    b_we = 1'b1; b_waddr = 6'd50; b_data = 8'hFF;
    tick();
    b_we = 1'b0; b_re = 1'b1; b_raddr = 6'd50;
    tick();
    check("oor_rd50", {b_qv, b_q}, {1'b1, 8'h00});
    b_raddr = 6'd47;
    tick();
    check("oor_rd47", {b_qv, b_q}, {1'b1, 8'h00});
    b_re = 1'b0; b_we = 1'b1; b_waddr = 6'd47; b_data = 8'h5A;
    tick();
    b_we = 1'b0; b_re = 1'b1; b_raddr = 6'd47;
    tick();
    check("top_rd47", {b_qv, b_q}, {1'b1, 8'h5A});
    b_re = 1'b0;

`ifdef RAM_DUAL_INIT_PARITY_EN
    // Injected parity error is flagged; clean words are not.
    a_we = 1'b1; a_waddr = 6'd3; a_data = 8'h12; a_inj = 1'b1;
    tick();
    a_we = 1'b0; a_inj = 1'b0; a_re = 1'b1; a_raddr = 6'd3;
    tick();
    check("par_err3", {a_perr, a_qv, a_q}, {1'b1, 1'b1, 8'h12});
    a_raddr = 6'd4;
    tick();
    check("par_ok4", {a_perr, a_qv}, {1'b0, 1'b1});
    a_we = 1'b1; a_waddr = 6'd6; a_raddr = 6'd6; a_data = 8'h13;
    tick();
    check("par_bypass", {a_perr, a_q}, {1'b0, 8'h13});
    a_we = 1'b0; a_re = 1'b0;
    tick();
    check("par_idle", a_perr, 1'b0);
`endif

    // Mid-init reset: restart sweep, stale 0x77 at 40 must be cleared.
    a_we = 1'b1; a_waddr = 6'd40; a_data = 8'h77;
    tick();
    a_we = 1'b0;
    reset = 1'b1;
    tick();
    check("rst2_busy", a_busy, 1'b1);
    check("rst2_q", {a_qv, a_q}, {1'b0, 8'h00});
    reset = 1'b0;
    repeat (20) tick();
    check("mid_busy", a_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(n_busy, saw_valid);
    check("reinit_cycles", n_busy, 64);
    a_re = 1'b1; a_raddr = 6'd40;
    tick();
    check("reinit_rd40", {a_qv, a_q}, {1'b1, 8'h00});
    a_raddr = 6'd5;
    tick();
    check("reinit_rd5", {a_qv, a_q}, {1'b1, 8'h00});
    a_raddr = 6'd0;
    tick();
    check("reinit_rd0", {a_qv, a_q}, {1'b1, 8'h00});
    a_re = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
